// File: rtl/seg_pkg.sv
// Shared constants and the active-low gfedcba hex decode table for the 7-segment scan monitor.
package seg_pkg;

   localparam logic [3:0] AN_BLANK   = 4'hF;
   localparam int         NUM_DIGITS = 4;

   // Returns {legal, nibble}; any pattern outside the hex font is illegal.
   function automatic logic [4:0] SEG_DECODE(input logic [6:0] pat);
      case (pat)
         7'h40:   return {1'b1, 4'h0};
         7'h79:   return {1'b1, 4'h1};
         7'h24:   return {1'b1, 4'h2};
         7'h30:   return {1'b1, 4'h3};
         7'h19:   return {1'b1, 4'h4};
         7'h12:   return {1'b1, 4'h5};
         7'h02:   return {1'b1, 4'h6};
         7'h78:   return {1'b1, 4'h7};
         7'h00:   return {1'b1, 4'h8};
         7'h10:   return {1'b1, 4'h9};
         7'h08:   return {1'b1, 4'hA};
         7'h03:   return {1'b1, 4'hB};
         7'h46:   return {1'b1, 4'hC};
         7'h21:   return {1'b1, 4'hD};
         7'h06:   return {1'b1, 4'hE};
         7'h0E:   return {1'b1, 4'hF};
         default: return 5'h00;
      endcase
   endfunction

endpackage

// File: rtl/seg_stable_detect.sv
// Settle filter: one-cycle sample pulse when {an,seg} has matched its history for SETTLE_CYCLES edges.
// Pulse lands SETTLE_CYCLES edges after the input changes; no backpressure, one pulse per dwell.
module seg_stable_detect
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   output logic       sample,
   output logic [3:0] held_an,
   output logic [6:0] held_seg
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   logic [CW-1:0] count;
   logic          match;

   assign match = ({an, seg} == {held_an, held_seg});

   always_ff @(posedge clk) begin
      if (reset) begin
         held_an  <= AN_BLANK;
         held_seg <= 7'h7F;
         count    <= '0;
         sample   <= 1'b0;
      end else begin
         held_an  <= an;
         held_seg <= seg;
         sample   <= 1'b0;
         if (match) begin
            if (count != CW'(SETTLE_CYCLES))
               count <= count + CW'(1);
            // Fires only on the transition into saturation, so a long dwell samples once.
            if (count == CW'(SETTLE_CYCLES - 1))
               sample <= 1'b1;
         end else begin
            count <= '0;
         end
      end
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs four scanned hex digits from AN/seg, flags faults, pulses once per in-order 0..3 frame.
// Outputs update SETTLE_CYCLES+1 edges after the buses change; passive monitor, no backpressure.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [3:0]  AN,
   input  logic [6:0]  seg,
   input  logic        clr_err,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_valid,
   output logic        an_err,
   output logic        seg_err,
   output logic        seq_err
);

   logic       sample;
   logic [3:0] s_an;
   logic [6:0] s_seg;

   seg_stable_detect #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_stable (
      .clk      (Clk),
      .reset    (Reset),
      .an       (AN),
      .seg      (seg),
      .sample   (sample),
      .held_an  (s_an),
      .held_seg (s_seg)
   );

   logic [6:0] pat;
   logic [4:0] dec;
   logic [3:0] low;
   logic       one_hot;
   logic [1:0] idx;
   logic       cap;
   logic       legal;
   logic       set_an;
   logic       set_seg;
   logic       set_seq;
   logic [1:0] expected;
   logic [3:0] seen;

   always_comb begin
      // The decode table is written active-low; active-high cathodes are folded into it here.
      pat     = SEG_ACTIVE_LOW ? s_seg : ~s_seg;
      dec     = SEG_DECODE(pat);
      low     = ~s_an;
      one_hot = $onehot(low);
      idx     = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (low[k]) idx = 2'(k);
      legal   = dec[4];
      cap     = sample && one_hot;
      set_an  = sample && (s_an != AN_BLANK) && !one_hot;
      set_seg = cap && !legal;
      set_seq = cap && legal && (idx != expected);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         digits      <= '0;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         an_err      <= 1'b0;
         seg_err     <= 1'b0;
         seq_err     <= 1'b0;
         expected    <= '0;
         seen        <= '0;
      end else begin
         frame_valid <= 1'b0;
         an_err      <= set_an  | (an_err  & ~clr_err);
         seg_err     <= set_seg | (seg_err & ~clr_err);
         seq_err     <= set_seq | (seq_err & ~clr_err);
         if (cap) begin
            if (!legal) begin
               digit_valid[idx] <= 1'b0;
            end else begin
               digits[{idx, 2'b00} +: 4] <= dec[3:0];
               digit_valid[idx]          <= 1'b1;
               expected                  <= idx + 2'd1;
               if (idx == 2'd3 && seen == 4'b0111) begin
                  frame_valid <= 1'b1;
                  seen        <= '0;
               end else if (idx == expected) begin
                  // Digit 0 always starts a fresh frame, discarding a partial one.
                  seen <= (idx == 2'd0) ? 4'b0001 : (seen | (4'b0001 << idx));
               end else begin
                  seen <= 4'b0001 << idx;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed and randomized checks of seg_scan_capture against a dwell-counting reference model.
module tb_seg_scan_capture;

   localparam int S = 2;
   localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  AN = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic        clr_err = 1'b0;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        an_err;
   logic        seg_err;
   logic        seq_err;

   seg_scan_capture #(.SETTLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .AN          (AN),
      .seg         (seg),
      .clr_err     (clr_err),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .an_err      (an_err),
      .seg_err     (seg_err),
      .seq_err     (seq_err)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int dut_frames = 0;
   int model_frames = 0;
   bit armed = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: a dwell is a run of identical {AN,seg} edges; the capture
   // happens on the edge after the run reaches S+1 edges.
   logic [10:0] m_prev;
   int          m_run;
   bit          m_pend;
   logic [10:0] m_cap;
   logic [3:0]  m_dig [4];
   bit          m_val [4];
   bit          m_frame, m_an, m_seg, m_seq;
   int          m_exp;
   bit          m_seen [4];

   function automatic int font_lookup(input logic [6:0] p);
      for (int n = 0; n < 16; n++)
         if (FONT[n] == p) return n;
      return -1;
   endfunction

   always @(posedge Clk) begin
      bit sa, ss, sq;
      sa = 0; ss = 0; sq = 0;
      m_frame = 0;
      if (Reset) begin
         m_prev = {4'hF, 7'h7F};
         m_run  = 1;
         m_pend = 0;
         m_exp  = 0;
         m_an = 0; m_seg = 0; m_seq = 0;
         for (int n = 0; n < 4; n++) begin
            m_dig[n] = 4'h0; m_val[n] = 0; m_seen[n] = 0;
         end
      end else begin
         if (m_pend) begin
            logic [3:0] a;
            int zeros, i, nib;
            a = m_cap[10:7];
            zeros = 0; i = 0;
            for (int n = 0; n < 4; n++)
               if (!a[n]) begin zeros++; i = n; end
            if (zeros > 1) begin
               sa = 1;
            end else if (zeros == 1) begin
               nib = font_lookup(m_cap[6:0]);
               if (nib < 0) begin
                  ss = 1;
                  m_val[i] = 0;
               end else begin
                  m_dig[i] = 4'(nib);
                  m_val[i] = 1;
                  if (i == 3 && m_seen[0] && m_seen[1] && m_seen[2] && !m_seen[3]) begin
                     m_frame = 1;
                     for (int n = 0; n < 4; n++) m_seen[n] = 0;
                  end else if (i == m_exp) begin
                     if (i == 0) for (int n = 1; n < 4; n++) m_seen[n] = 0;
                     m_seen[i] = 1;
                  end else begin
                     sq = 1;
                     for (int n = 0; n < 4; n++) m_seen[n] = (n == i);
                  end
                  m_exp = (i + 1) % 4;
               end
            end
         end
         m_an  = sa | (m_an  & !clr_err);
         m_seg = ss | (m_seg & !clr_err);
         m_seq = sq | (m_seq & !clr_err);
         if ({AN, seg} == m_prev) m_run++;
         else begin m_run = 1; m_prev = {AN, seg}; end
         m_pend = (m_run == S + 1);
         m_cap  = {AN, seg};
      end
      if (m_frame) model_frames++;
   end

   always @(negedge Clk) begin
      if (armed) begin
         chk("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
         chk("digit_valid", 16'(digit_valid), 16'({m_val[3], m_val[2], m_val[1], m_val[0]}));
         chk("frame_valid", 16'(frame_valid), 16'(m_frame));
         chk("errs", 16'({an_err, seg_err, seq_err}), 16'({m_an, m_seg, m_seq}));
      end
      if (frame_valid) dut_frames++;
   end

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input bit c = 0);
      AN = a; seg = s; clr_err = c;
      @(negedge Clk);
      clr_err = 0;
      repeat (n - 1) @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1; AN = 4'hF; seg = 7'h7F; clr_err = 0;
      repeat (2) @(negedge Clk);
      Reset = 0;
   endtask

   initial begin
      @(negedge Clk);
      do_reset();
      armed = 1;
      chk("reset_digits", digits, 16'h0000);
      chk("reset_flags", 16'({digit_valid, frame_valid, an_err, seg_err, seq_err}), 16'h0000);

      hold(4'hE, 7'h24, 4);
      chk("first_digit", 16'(digits[3:0]), 16'h2);
      chk("first_valid", 16'(digit_valid), 16'h1);

      do_reset();
      dut_frames = 0;
      hold(4'hE, 7'h79, 5); hold(4'hD, 7'h30, 5); hold(4'hB, 7'h19, 5); hold(4'h7, 7'h40, 5);
      chk("scan_digits", digits, 16'h0431);
      chk("scan_valid", 16'(digit_valid), 16'hF);
      chk("scan_frames", 16'(dut_frames), 16'd1);
      chk("scan_seq_err", 16'(seq_err), 16'h0);

      hold(4'hE, 7'h06, 4); hold(4'hD, 7'h12, 1); hold(4'hD, 7'h21, 4);
      chk("glitch_digits", digits, 16'h04DE);
      chk("glitch_errs", 16'({an_err, seg_err, seq_err}), 16'h0);

      hold(4'hC, 7'h40, 4);
      chk("an_err_set", 16'(an_err), 16'h1);
      hold(4'hE, 7'h7F, 4);
      chk("seg_err_set", 16'(seg_err), 16'h1);
      chk("seg_err_valid0", 16'(digit_valid[0]), 16'h0);
      chk("seg_err_digit0", 16'(digits[3:0]), 16'hE);
      hold(4'hF, 7'h7F, 3, 1'b1);
      chk("clr_err", 16'({an_err, seg_err}), 16'h0);

      do_reset();
      dut_frames = 0;
      hold(4'hE, 7'h40, 4); hold(4'h7, 7'h40, 4);
      chk("seq_err_set", 16'(seq_err), 16'h1);
      chk("seq_no_frame", 16'(dut_frames), 16'd0);

      do_reset();
      hold(4'hE, 7'h79, 4); hold(4'hD, 7'h30, 4);
      do_reset();
      chk("midframe_reset", 16'({digits, digit_valid, frame_valid, an_err, seg_err, seq_err} != 0),
          16'h0);

      dut_frames = 0;
      model_frames = 0;
      begin
         int nxt;
         nxt = 0;
         for (int k = 0; k < 900; k++) begin
            int r, dw;
            logic [3:0] a;
            logic [6:0] s;
            r  = $urandom_range(0, 99);
            dw = $urandom_range(3, 6);
            s  = FONT[$urandom_range(0, 15)];
            a  = ~(4'b0001 << nxt);
            if (r < 70) begin
               nxt = (nxt + 1) % 4;
            end else if (r < 78) begin
               a = ~(4'b0001 << $urandom_range(0, 3));
            end else if (r < 83) begin
               s = 7'($urandom);
            end else if (r < 88) begin
               a = 4'($urandom);
            end else if (r < 93) begin
               a = 4'hF;
            end else if (r < 98) begin
               dw = $urandom_range(1, S);
            end else begin
               Reset = 1;
               dw = 1;
            end
            hold(a, s, dw, ($urandom_range(0, 15) == 0));
            Reset = 0;
         end
      end
      chk("rand_frames_match", 16'(dut_frames), 16'(model_frames));
      chk("rand_frames_seen", 16'(model_frames > 10), 16'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
